bin2x2_reduce: RTL and testbench



---
 rtl/bin_pkg.sv | 17 +
 rtl/bin_line_buf.sv | 27 ++
 rtl/bin2x2_reduce.sv | 113 +++++++++++
 tb/tb_bin2x2_reduce.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin_pkg.sv
// Shared types and constants for the 2x2 binning datapath.
package bin_pkg;

  localparam int unsigned LANES = 8;
  localparam int unsigned PIX_W = 12;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [PIX_W:0]   hsum_t;
  typedef logic [PIX_W+1:0] vsum_t;

  typedef enum logic {ROW_EVEN, ROW_ODD} row_state_t;

  function automatic hsum_t pair_sum(input pix_t a, input pix_t b);
    return hsum_t'(a) + hsum_t'(b);
  endfunction

endpackage

// File: rtl/bin_line_buf.sv
// One-row store of horizontal pair sums; synchronous write, asynchronous read, no reset.
module bin_line_buf
  import bin_pkg::*;
#(
  parameter int unsigned DEPTH = 60,
  parameter int unsigned AW    = 6,
  parameter int unsigned DW    = 4 * $bits(hsum_t)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bin2x2_reduce.sv
// 2x2 binning of an 8-lane pixel stream into 4-lane averaged words.
// Define BIN2X2_ROUND_EN for round-half-up; otherwise the average truncates.
module bin2x2_reduce
  import bin_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 60,
  parameter int unsigned CW         = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANES*PIX_W-1:0]   in_data,
  input  logic                     in_valid,
  input  logic                     in_sof,
  output logic                     in_ready,
  output logic [LANES/2*PIX_W-1:0] out_data,
  output logic                     out_valid,
  output logic                     out_eol,
  input  logic                     out_ready,
  output logic                     sof_err
);

  localparam int unsigned NOUT = LANES / 2;
  localparam logic [CW-1:0] LAST_COL = CW'(LINE_WORDS - 1);
`ifdef BIN2X2_ROUND_EN
  localparam vsum_t RND = vsum_t'(2);
`else
  localparam vsum_t RND = vsum_t'(0);
`endif

  row_state_t state_q, state_d, eff_state;
  logic [CW-1:0] col_q, col_d, eff_col;
  logic accept, at_frame_start, buf_we;
  hsum_t [NOUT-1:0] h_cur, h_even;
  logic [NOUT*PIX_W-1:0] bin_pix;

  assign in_ready       = (state_q == ROW_EVEN) || !out_valid || out_ready;
  assign accept         = in_valid && in_ready;
  assign at_frame_start = (state_q == ROW_EVEN) && (col_q == '0);
  assign buf_we         = accept && (eff_state == ROW_EVEN);

  // A start-of-frame word is always column 0 of an even row, whatever we thought before.
  always_comb begin
    eff_state = state_q;
    eff_col   = col_q;
    if (in_sof) begin
      eff_state = ROW_EVEN;
      eff_col   = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    if (accept) begin
      state_d = eff_state;
      if (eff_col == LAST_COL) begin
        col_d   = '0;
        state_d = (eff_state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
      end else begin
        col_d = eff_col + CW'(1);
      end
    end
  end

  always_comb begin
    h_cur   = '0;
    bin_pix = '0;
    for (int j = 0; j < NOUT; j++) begin
      h_cur[j] = pair_sum(in_data[2*j*PIX_W +: PIX_W], in_data[(2*j+1)*PIX_W +: PIX_W]);
      bin_pix[j*PIX_W +: PIX_W] =
          PIX_W'((vsum_t'(h_even[j]) + vsum_t'(h_cur[j]) + RND) >> 2);
    end
  end

  bin_line_buf #(
    .DEPTH (LINE_WORDS),
    .AW    (CW),
    .DW    (NOUT * $bits(hsum_t))
  ) u_line_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (eff_col),
    .wdata (h_cur),
    .raddr (eff_col),
    .rdata (h_even)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ROW_EVEN;
      col_q     <= '0;
      out_valid <= 1'b0;
      out_eol   <= 1'b0;
      out_data  <= '0;
      sof_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      if (accept && in_sof && !at_frame_start) begin
        sof_err <= 1'b1;
      end
      if (accept && (eff_state == ROW_ODD)) begin
        out_valid <= 1'b1;
        out_data  <= bin_pix;
        out_eol   <= (eff_col == LAST_COL);
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_eol   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bin2x2_reduce.sv
// Scoreboard bench for bin2x2_reduce: random handshakes against a row-level reference model.
module tb_bin2x2_reduce;

  localparam int LW = 60;
`ifdef BIN2X2_ROUND_EN
  localparam int RND = 2;
`else
  localparam int RND = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] in_data;
  logic        in_valid, in_sof, in_ready;
  logic [47:0] out_data;
  logic        out_valid, out_eol, out_ready, sof_err;

  always #5 clk = ~clk;

  bin2x2_reduce dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_eol   (out_eol),
    .out_ready (out_ready),
    .sof_err   (sof_err)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [48:0] exp_q[$];
  int ebuf[LW][8];
  bit m_odd = 0;
  int m_col = 0;
  bit exp_sof_err = 0;
  int valid_pct = 100;
  int rdy_pct = 100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pixel j of an output is the rounded/truncated mean of the 2x2 block.
  task automatic model_accept(input logic [95:0] w, input bit sof);
    logic [48:0] e;
    int s;
    if (sof) begin
      if (m_odd || m_col != 0) exp_sof_err = 1;
      m_odd = 0;
      m_col = 0;
    end
    if (!m_odd) begin
      for (int k = 0; k < 8; k++) ebuf[m_col][k] = int'(w[12*k +: 12]);
    end else begin
      e = '0;
      for (int j = 0; j < 4; j++) begin
        s = ebuf[m_col][2*j] + ebuf[m_col][2*j+1] + int'(w[24*j +: 12]) + int'(w[24*j+12 +: 12]);
        e[12*j +: 12] = 12'((s + RND) / 4);
      end
      e[48] = (m_col == LW - 1);
      exp_q.push_back(e);
    end
    m_col++;
    if (m_col == LW) begin
      m_col = 0;
      m_odd = !m_odd;
    end
  endtask

  task automatic send(input logic [95:0] w, input bit sof);
    bit done = 0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      in_data   = w;
      in_sof    = sof;
      in_valid  = ($urandom_range(0, 99) < valid_pct);
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      #1;
      check("sof_err", sof_err, exp_sof_err);
      if (!m_odd || out_ready) check("in_ready", in_ready, 1);
      if (in_valid && in_ready) begin
        model_accept(w, sof);
        done = 1;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: word never accepted, in_ready=%0b", in_ready);
    end
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid  = 1;
      in_sof    = 0;
      out_ready = 0;
      #1;
      check("stall_in_ready", in_ready, 0);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) begin
      @(negedge clk);
      in_valid  = 0;
      in_sof    = 0;
      out_ready = 1;
    end
    repeat (3) @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("idle_valid", out_valid, 0);
  endtask

  function automatic logic [95:0] fill(input int v);
    logic [95:0] w;
    for (int k = 0; k < 8; k++) w[12*k +: 12] = 12'(v);
    return w;
  endfunction

  function automatic logic [95:0] make(input int kind, input int r, input int c);
    logic [95:0] w;
    w = '0;
    case (kind)
      0: w = fill(100);
      1: w = fill(4095);
      2: w = fill(r == 0 ? 1 : 2);
      3: if (r == 0) w[11:0] = 12'(c);
      default: for (int k = 0; k < 8; k++) w[12*k +: 12] = 12'($urandom_range(0, 4095));
    endcase
    return w;
  endfunction

  task automatic frame(input int kind, input int stall_col);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < LW; c++) begin
        send(make(kind, r, c), (r == 0 && c == 0));
        if (r == 1 && c == stall_col) stall(5);
      end
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks hold stability.
  bit prev_hold = 0;
  logic [48:0] held;
  initial begin
    logic [48:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rst !== 1'b0) begin
        prev_hold = 0;
      end else begin
        if (prev_hold) check("out_hold", {out_valid, out_eol, out_data}, {1'b1, held});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_out: got %0h with empty scoreboard", {out_eol, out_data});
          end else begin
            e = exp_q.pop_front();
            check("out_word", {out_eol, out_data}, e);
          end
        end
        prev_hold = out_valid && !out_ready;
        held = {out_eol, out_data};
      end
    end
  end

  initial begin
    rst = 1; in_valid = 0; in_sof = 0; in_data = '0; out_ready = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_eol", out_eol, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sof_err", sof_err, 0);
    check("rst_in_ready", in_ready, 1);

    frame(0, -1); drain();   // constant 100
    frame(1, -1); drain();   // max values
    frame(2, -1); drain();   // rounding boundary
    frame(0, 20); drain();   // backpressure mid odd row
    frame(3, -1); drain();   // column ordering

    // Resync at even column 17, then a full fresh frame.
    for (int c = 0; c < 17; c++) send(fill(7), c == 0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < LW; c++) send(make(4, r, c), (r == 0 && c == 0));
    drain();

    valid_pct = 70; rdy_pct = 60;
    frame(4, -1); frame(4, -1); drain();
    valid_pct = 100; rdy_pct = 100;

    // Reset at odd column 30 with an output pending.
    for (int c = 0; c < LW; c++) send(make(4, 0, c), c == 0);
    for (int c = 0; c < 30; c++) send(make(4, 1, c), 0);
    @(negedge clk);
    rst = 1; in_valid = 0; in_sof = 0; out_ready = 0;
    exp_q.delete();
    #1;
    check("pre_reset_valid", out_valid, 1);
    @(negedge clk);
    rst = 0;
    m_odd = 0; m_col = 0; exp_sof_err = 0;
    #1;
    check("post_reset_valid", out_valid, 0);
    check("post_reset_sof_err", sof_err, 0);
    frame(4, -1); drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
